core_mem_arbiter: RTL
=====================

Name: core_mem_arbiter

Overview:
- Shares the core's single memory bus port between the instruction-fetch requester (I) and the load/store requester (D).
- Grants one requester at a time and latches its request into a register slice.
- Drives the request onto the memory bus, then routes the response back to the granted requester.
- A response timeout converts a hung memory transaction into an error response, so the core's stage handshakes always complete.

Parameters:
- AW, 32, address width.
- DW, 32, data width; strobe width is DW/8.
- TIMEOUT, 255, cycles to wait for a response after memory accepts a request; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- i_req_valid  in  1  instruction request valid.
- i_req_ready  out  1  instruction request accepted this cycle.
- i_req_addr  in  AW  instruction address (read only).
- i_resp_valid  out  1  instruction response, 1-cycle pulse.
- i_resp_rdata  out  DW  instruction read data.
- i_resp_err  out  1  instruction bus error.
- d_req_valid  in  1  data request valid.
- d_req_ready  out  1  data request accepted this cycle.
- d_req_addr  in  AW  data address.
- d_req_write  in  1  1 = store.
- d_req_wdata  in  DW  store data.
- d_req_wstrb  in  DW/8  byte strobes.
- d_resp_valid  out  1  data response, 1-cycle pulse.
- d_resp_rdata  out  DW  load data.
- d_resp_err  out  1  data bus error.
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory accepts the request.
- mem_addr  out  AW  latched address.
- mem_write  out  1  latched write flag.
- mem_wdata  out  DW  latched write data.
- mem_wstrb  out  DW/8  latched strobes.
- mem_resp_valid  in  1  memory response.
- mem_resp_rdata  in  DW  memory read data.
- mem_resp_err  in  1  memory error.

Behaviour:
- The state machine has three states: IDLE, REQ, RESP. An owner register (I/D) and a last_grant register track arbitration.
- Reset (rst=1 at a clk edge), including mid-transaction:
  - state=IDLE, owner=I, last_grant=D, timeout counter=0.
  - The latched mem_addr/mem_wdata/mem_wstrb/mem_write registers are reset to 0.
  - All valid and ready outputs are 0; any in-flight transaction is abandoned with no response.
- IDLE:
  - Arbitration is round-robin. If only one requester is valid, grant it. If both are valid, grant the one that is not last_grant.
  - The granted requester's req_ready=1 combinationally in the same cycle; the other requester's req_ready=0.
  - On grant: latch the fields, set owner and last_grant, go to REQ.
  - An I request latches write=0, wdata=0, wstrb=0.
  - No requester valid: stay in IDLE.
- REQ:
  - mem_req_valid=1 with the latched fields, held stable until mem_req_ready.
  - No timeout applies in REQ.
  - mem_req_ready=1: go to RESP and clear the counter.
- RESP:
  - mem_resp_valid=1: assert owner's resp_valid in the same cycle, with rdata and err passed through combinationally; go to IDLE.
  - Otherwise, if TIMEOUT≠0, increment the counter. When the counter reaches TIMEOUT with no response: owner resp_valid=1, err=1, rdata=0; go to IDLE.
- The non-owner's resp_valid is always 0. resp_rdata and resp_err are 0 whenever the corresponding resp_valid=0.
- mem_resp_valid outside RESP (including a late response after a timeout) is ignored.
- Memory must not respond in the same cycle it accepts a request.
- Minimum transaction length: 3 cycles, covering grant, REQ and RESP. The earliest response is 2 cycles after the grant cycle.
- req_ready is never 1 outside IDLE, so each requester has at most one outstanding transaction and the block has at most one in total.
- The counter is $clog2(TIMEOUT+1) bits wide and saturates at TIMEOUT.
- Requesters must hold req_valid and the request fields until req_ready; the block does not check this.

Test Plan:
- Single I read: i_req_valid, addr=0x100; mem_req_ready 1 cycle later; mem_resp rdata=0xDEADBEEF 2 cycles later → i_req_ready pulses in cycle 0; mem_req_valid with mem_addr=0x100, mem_write=0; i_resp_valid with 0xDEADBEEF; d_resp_valid stays 0.
- D store: addr=0x2004, wdata=0x12345678, wstrb=0b0011, with mem_req_ready held low 3 cycles → mem_req_valid and all fields stable for 4 cycles; d_resp_valid with err=0 after the response.
- Simultaneous I and D requests held continuously after reset → grant order I, D, I, D; each transaction finishes before the next grant; last_grant alternates.
- Timeout with TIMEOUT=4: D read accepted by memory, no response → d_resp_valid with err=1 and rdata=0 exactly 4 cycles after entering RESP. A late mem_resp_valid in IDLE produces no response pulse.
- Memory error: mem_resp_err=1 on an I fetch → i_resp_err=1 for one cycle; the next transaction proceeds normally.
- Reset asserted in RESP → next cycle state=IDLE and all outputs 0. A subsequent I and D tie grants I first.

Source files
------------

// File: rtl/core_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// core_mem_arbiter_if
//   Bundles the three buses that meet at core_mem_arbiter:
//     - instruction-fetch requester (i_*): read-only request, response pulse
//     - load/store requester (d_*): read/write request with strobes
//     - shared memory port (mem_*): one latched request, one response
//   Modports:
//     master : the arbiter's view (it answers both requesters and drives memory)
//     slave  : the environment's view (requesters plus memory model)
// -----------------------------------------------------------------------------
interface core_mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  localparam int SW = DW / 8;

  // Instruction requester
  logic          i_req_valid;
  logic          i_req_ready;
  logic [AW-1:0] i_req_addr;
  logic          i_resp_valid;
  logic [DW-1:0] i_resp_rdata;
  logic          i_resp_err;

  // Data requester
  logic          d_req_valid;
  logic          d_req_ready;
  logic [AW-1:0] d_req_addr;
  logic          d_req_write;
  logic [DW-1:0] d_req_wdata;
  logic [SW-1:0] d_req_wstrb;
  logic          d_resp_valid;
  logic [DW-1:0] d_resp_rdata;
  logic          d_resp_err;

  // Memory port
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic [AW-1:0] mem_addr;
  logic          mem_write;
  logic [DW-1:0] mem_wdata;
  logic [SW-1:0] mem_wstrb;
  logic          mem_resp_valid;
  logic [DW-1:0] mem_resp_rdata;
  logic          mem_resp_err;

  modport master (
    input  i_req_valid, i_req_addr,
    output i_req_ready, i_resp_valid, i_resp_rdata, i_resp_err,
    input  d_req_valid, d_req_addr, d_req_write, d_req_wdata, d_req_wstrb,
    output d_req_ready, d_resp_valid, d_resp_rdata, d_resp_err,
    output mem_req_valid, mem_addr, mem_write, mem_wdata, mem_wstrb,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err
  );

  modport slave (
    output i_req_valid, i_req_addr,
    input  i_req_ready, i_resp_valid, i_resp_rdata, i_resp_err,
    output d_req_valid, d_req_addr, d_req_write, d_req_wdata, d_req_wstrb,
    input  d_req_ready, d_resp_valid, d_resp_rdata, d_resp_err,
    input  mem_req_valid, mem_addr, mem_write, mem_wdata, mem_wstrb,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err
  );
endinterface

// File: rtl/core_mem_arbiter.sv
// -----------------------------------------------------------------------------
// core_mem_arbiter
//   Shares one memory bus port between the instruction-fetch requester (I) and
//   the load/store requester (D). One transaction is in flight at a time:
//   IDLE grants a requester round-robin and latches its request, REQ presents
//   the latched request until memory accepts it, RESP routes the response to
//   the owner. A response timeout in RESP turns a hung memory into an error
//   response so the core's handshakes always complete.
//   Ports:
//     clk  : clock
//     rst  : synchronous, active-high reset
//     bus  : core_mem_arbiter_if.master (I requester, D requester, memory)
//   Parameters:
//     AW, DW  : address / data width (strobes are DW/8)
//     TIMEOUT : response wait limit in cycles after acceptance, 0 disables
// -----------------------------------------------------------------------------
module core_mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  core_mem_arbiter_if.master  bus
);
  localparam int SW = DW / 8;
  // Keep the counter at least 1 bit wide so TIMEOUT=0 still elaborates.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;
  typedef enum logic       {OWN_I = 1'b0, OWN_D = 1'b1} owner_t;

  state_t        r_state, w_state_nxt;
  owner_t        r_owner, r_last_grant, w_grant;
  logic          w_grant_valid;
  logic          w_accept;
  logic [CW-1:0] r_cnt;
  logic          w_timeout_hit;
  logic          w_resp_fire;
  logic [DW-1:0] w_resp_rdata;
  logic          w_resp_err;

  logic [AW-1:0] r_addr;
  logic          r_write;
  logic [DW-1:0] r_wdata;
  logic [SW-1:0] r_wstrb;

  // Round-robin: a lone requester wins; on a tie the one not granted last wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would infer a latch.
    w_grant       = OWN_I;
    w_grant_valid = 1'b0;
    if (bus.i_req_valid && bus.d_req_valid) begin
      w_grant_valid = 1'b1;
      w_grant       = (r_last_grant == OWN_I) ? OWN_D : OWN_I;
    end else if (bus.i_req_valid) begin
      w_grant_valid = 1'b1;
      w_grant       = OWN_I;
    end else if (bus.d_req_valid) begin
      w_grant_valid = 1'b1;
      w_grant       = OWN_D;
    end
  end

  assign w_accept      = (r_state == S_IDLE) && w_grant_valid && !rst;
  assign w_timeout_hit = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT));
  // A real response always wins over a timeout landing in the same cycle.
  assign w_resp_fire   = (r_state == S_RESP) && (bus.mem_resp_valid || w_timeout_hit);
  assign w_resp_rdata  = bus.mem_resp_valid ? bus.mem_resp_rdata : '0;
  assign w_resp_err    = bus.mem_resp_valid ? bus.mem_resp_err   : 1'b1;

  // Next state
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (w_grant_valid)      w_state_nxt = S_REQ;
      S_REQ:  if (bus.mem_req_ready)  w_state_nxt = S_RESP;
      S_RESP: if (w_resp_fire)        w_state_nxt = S_IDLE;
      default:                        w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs. Everything is forced low while rst is high so an abandoned
  // transaction never leaks a response or a grant during reset.
  always_comb begin
    bus.i_req_ready   = 1'b0;
    bus.d_req_ready   = 1'b0;
    bus.i_resp_valid  = 1'b0;
    bus.i_resp_rdata  = '0;
    bus.i_resp_err    = 1'b0;
    bus.d_resp_valid  = 1'b0;
    bus.d_resp_rdata  = '0;
    bus.d_resp_err    = 1'b0;
    bus.mem_req_valid = 1'b0;
    if (!rst) begin
      if (r_state == S_IDLE && w_grant_valid) begin
        bus.i_req_ready = (w_grant == OWN_I);
        bus.d_req_ready = (w_grant == OWN_D);
      end
      bus.mem_req_valid = (r_state == S_REQ);
      if (w_resp_fire) begin
        if (r_owner == OWN_I) begin
          bus.i_resp_valid = 1'b1;
          bus.i_resp_rdata = w_resp_rdata;
          bus.i_resp_err   = w_resp_err;
        end else begin
          bus.d_resp_valid = 1'b1;
          bus.d_resp_rdata = w_resp_rdata;
          bus.d_resp_err   = w_resp_err;
        end
      end
    end
  end

  assign bus.mem_addr  = r_addr;
  assign bus.mem_write = r_write;
  assign bus.mem_wdata = r_wdata;
  assign bus.mem_wstrb = r_wstrb;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_owner      <= OWN_I;
      r_last_grant <= OWN_D;
      r_cnt        <= '0;
      // NOTE: the request slice is reset too, so memory sees a clean all-zero
      // bus after reset rather than whatever was latched mid-transaction.
      r_addr       <= '0;
      r_write      <= 1'b0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (w_accept) begin
        r_owner      <= w_grant;
        r_last_grant <= w_grant;
        if (w_grant == OWN_I) begin
          r_addr  <= bus.i_req_addr;
          r_write <= 1'b0;
          r_wdata <= '0;
          r_wstrb <= '0;
        end else begin
          r_addr  <= bus.d_req_addr;
          r_write <= bus.d_req_write;
          r_wdata <= bus.d_req_wdata;
          r_wstrb <= bus.d_req_wstrb;
        end
      end

      // The counter is held at zero through REQ, so it starts from zero on
      // entry to RESP, then counts no-response cycles and saturates.
      if (r_state == S_REQ) begin
        r_cnt <= '0;
      end else if (r_state == S_RESP && TIMEOUT != 0 && !bus.mem_resp_valid
                   && !w_timeout_hit) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule
